// File: rtl/ballplayer_image_selector.sv
// Image-selection controller between the keypad pulse vector and the LCD image engine.
// Decodes direct/next/prev/auto keys into a target image and issues one load at a time over req/ack.
module ballplayer_image_selector #(
    parameter int NUM_KEYS    = 16,
    parameter int NUM_IMAGES  = 8,
    parameter int KEY_NEXT    = 12,
    parameter int KEY_PREV    = 13,
    parameter int KEY_AUTO    = 14,
    parameter int AUTO_PERIOD = 36_000_000,
    parameter int ACK_TIMEOUT = 24_000_000,
    localparam int ID_W       = $clog2(NUM_IMAGES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_pulse,
    input  logic                load_ack,
    output logic                load_req,
    output logic [ID_W-1:0]     load_id,
    output logic [ID_W-1:0]     cur_id,
    output logic [ID_W-1:0]     target_id,
    output logic                auto_mode,
    output logic                key_hit,
    output logic                ack_err
);

    localparam int KEY_W  = $clog2(NUM_KEYS);
    localparam int AUTO_W = $clog2(AUTO_PERIOD);
    localparam int TO_W   = $clog2(ACK_TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_load_req;
    logic [ID_W-1:0]     r_load_id;
    logic [ID_W-1:0]     r_cur_id;
    logic                r_cur_valid;
    logic [ID_W-1:0]     r_target_id;
    logic                r_auto_mode;
    logic                r_key_hit;
    logic                r_ack_err;
    logic [AUTO_W-1:0]   r_auto_cnt;
    logic [TO_W-1:0]     r_to_cnt;

    logic [NUM_KEYS-1:0] w_key_mask;
    logic                w_key_valid;
    logic [KEY_W-1:0]    w_key_sel;
    logic                w_auto_tick;
    logic [ID_W-1:0]     w_target_nxt;
    logic                w_auto_nxt;

    function automatic logic key_known(input int k);
        return (k < NUM_IMAGES) || (k == KEY_NEXT) || (k == KEY_PREV) || (k == KEY_AUTO);
    endfunction

    function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_IMAGES - 1)) ? {ID_W{1'b0}} : id + ID_W'(1);
    endfunction

    function automatic logic [ID_W-1:0] id_dec(input logic [ID_W-1:0] id);
        return (id == {ID_W{1'b0}}) ? ID_W'(NUM_IMAGES - 1) : id - ID_W'(1);
    endfunction

    // Lowest-index recognised key wins; unrecognised pulses never reach the decoder.
    always_comb begin
        w_key_mask  = {NUM_KEYS{1'b0}};
        w_key_valid = 1'b0;
        w_key_sel   = {KEY_W{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_key_mask[i] = key_pulse[i] & key_known(i);
            w_key_sel     = (!w_key_valid && w_key_mask[i]) ? KEY_W'(i) : w_key_sel;
            w_key_valid   = w_key_valid | w_key_mask[i];
        end
    end

    assign w_auto_tick = r_auto_mode && (r_state == S_IDLE) && !w_key_valid &&
                         (r_auto_cnt == AUTO_W'(AUTO_PERIOD - 1));

    // Next target/auto-mode; next/prev are relative to the target so repeated presses accumulate.
    always_comb begin
        w_target_nxt = r_target_id;
        w_auto_nxt   = r_auto_mode;
        if (w_key_valid) begin
            if (w_key_sel < KEY_W'(NUM_IMAGES)) begin
                w_target_nxt = ID_W'(w_key_sel);
            end else if (w_key_sel == KEY_W'(KEY_NEXT)) begin
                w_target_nxt = id_inc(r_target_id);
            end else if (w_key_sel == KEY_W'(KEY_PREV)) begin
                w_target_nxt = id_dec(r_target_id);
            end else begin
                w_auto_nxt = ~r_auto_mode;
            end
        end else if (w_auto_tick) begin
            w_target_nxt = id_inc(r_target_id);
        end else begin
            w_target_nxt = r_target_id;
        end
    end

    // Key-driven state: selected target, slideshow mode and the key_hit strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target_id <= {ID_W{1'b0}};
            r_auto_mode <= 1'b0;
            r_key_hit   <= 1'b0;
        end else begin
            r_target_id <= w_target_nxt;
            r_auto_mode <= w_auto_nxt;
            r_key_hit   <= w_key_valid;
        end
    end

    // Slideshow interval counter; pauses while a load is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= {AUTO_W{1'b0}};
        end else if (w_key_valid || !r_auto_mode) begin
            r_auto_cnt <= {AUTO_W{1'b0}};
        end else if (r_state == S_IDLE) begin
            r_auto_cnt <= w_auto_tick ? {AUTO_W{1'b0}} : r_auto_cnt + AUTO_W'(1);
        end else begin
            r_auto_cnt <= r_auto_cnt;
        end
    end

    // Load handshake FSM: load_id is frozen while a request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_load_req  <= 1'b0;
            r_load_id   <= {ID_W{1'b0}};
            r_cur_id    <= {ID_W{1'b0}};
            r_cur_valid <= 1'b0;
            r_ack_err   <= 1'b0;
            r_to_cnt    <= {TO_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_cur_valid || (r_target_id != r_cur_id)) begin
                        r_state    <= S_REQ;
                        r_load_req <= 1'b1;
                        r_load_id  <= r_target_id;
                        r_to_cnt   <= {TO_W{1'b0}};
                    end else begin
                        r_state    <= S_IDLE;
                        r_load_req <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (load_ack) begin
                        r_state     <= S_IDLE;
                        r_load_req  <= 1'b0;
                        r_cur_id    <= r_load_id;
                        r_cur_valid <= 1'b1;
                        r_ack_err   <= 1'b0;
                    end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        r_state    <= S_IDLE;
                        r_load_req <= 1'b0;
                        r_ack_err  <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_load_req <= 1'b0;
                end
            endcase
        end
    end

    assign load_req  = r_load_req;
    assign load_id   = r_load_id;
    assign cur_id    = r_cur_id;
    assign target_id = r_target_id;
    assign auto_mode = r_auto_mode;
    assign key_hit   = r_key_hit;
    assign ack_err   = r_ack_err;

endmodule

// File: tb/tb_ballplayer_image_selector.sv
// Directed self-checking bench for ballplayer_image_selector (AUTO_PERIOD=100, ACK_TIMEOUT=50).
`timescale 1ns/1ps
module tb_ballplayer_image_selector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] key_pulse;
    logic        load_ack;
    logic        load_req;
    logic [2:0]  load_id;
    logic [2:0]  cur_id;
    logic [2:0]  target_id;
    logic        auto_mode;
    logic        key_hit;
    logic        ack_err;

    int n_assert = 0;
    int n_fail   = 0;

    ballplayer_image_selector #(
        .NUM_KEYS(16), .NUM_IMAGES(8), .KEY_NEXT(12), .KEY_PREV(13), .KEY_AUTO(14),
        .AUTO_PERIOD(100), .ACK_TIMEOUT(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .load_ack(load_ack),
        .load_req(load_req), .load_id(load_id), .cur_id(cur_id), .target_id(target_id),
        .auto_mode(auto_mode), .key_hit(key_hit), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int k);
        key_pulse = 16'h0001 << k;
        step();
        key_pulse = 16'h0000;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},    load_req,  32'd0);
        chk({tag, "_id"},     load_id,   32'd0);
        chk({tag, "_cur"},    cur_id,    32'd0);
        chk({tag, "_tgt"},    target_id, 32'd0);
        chk({tag, "_auto"},   auto_mode, 32'd0);
        chk({tag, "_hit"},    key_hit,   32'd0);
        chk({tag, "_err"},    ack_err,   32'd0);
    endtask

    // Wait (bounded) for a request, check its id, ack it 3 cycles after it rose.
    task automatic serve(input string tag, input logic [2:0] exp, input int budget);
        int k;
        k = 0;
        while (load_req !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_req"}, load_req, 32'd1);
        chk({tag, "_id"},  load_id,  {29'd0, exp});
        step();
        step();
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        chk({tag, "_cur"},  cur_id,   {29'd0, exp});
        chk({tag, "_drop"}, load_req, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int   n;
        logic [2:0] exp_id;
        rst_n     = 1'b0;
        key_pulse = 16'h0000;
        load_ack  = 1'b0;
        step();
        step();
        chk_reset("rst");

        // Post-reset forced load of image 0
        rst_n = 1'b1;
        step();
        chk("boot_req", load_req, 32'd1);
        chk("boot_id",  load_id,  32'd0);
        serve("boot", 3'd0, 5);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            saw = saw | load_req;
        end
        chk("boot_noreq", saw, 32'd0);

        // Direct select
        pulse(5);
        chk("k5_hit", key_hit,   32'd1);
        chk("k5_tgt", target_id, 32'd5);
        step();
        chk("k5_hit_clr", key_hit, 32'd0);
        serve("k5", 3'd5, 5);

        // Prev/next wrap
        pulse(0);
        serve("k0", 3'd0, 5);
        pulse(13);
        chk("prev_wrap", target_id, 32'd7);
        serve("prev", 3'd7, 5);
        pulse(12);
        chk("next_wrap", target_id, 32'd0);
        serve("next", 3'd0, 5);

        // Latest request wins while a load is pending
        pulse(1);
        step();
        chk("pend_req", load_req, 32'd1);
        chk("pend_id",  load_id,  32'd1);
        pulse(2);
        pulse(3);
        chk("pend_tgt",    target_id, 32'd3);
        chk("pend_frozen", load_id,   32'd1);
        for (int i = 0; i < 8; i++) step();
        chk("pend_hold_req", load_req, 32'd1);
        chk("pend_hold_id",  load_id,  32'd1);
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
        chk("pend_ack_cur", cur_id,   32'd1);
        chk("pend_ack_drop", load_req, 32'd0);
        step();
        chk("pend_re_req", load_req, 32'd1);
        chk("pend_re_id",  load_id,  32'd3);
        serve("pend3", 3'd3, 2);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            saw = saw | load_req;
        end
        chk("pend_noreq", saw, 32'd0);

        // Simultaneous keys: lowest wins
        key_pulse = 16'h0030;
        step();
        key_pulse = 16'h0000;
        chk("multi_hit", key_hit,   32'd1);
        chk("multi_tgt", target_id, 32'd4);
        serve("multi", 3'd4, 5);

        // Unmapped key ignored
        key_pulse = 16'h8000;
        step();
        key_pulse = 16'h0000;
        chk("unk_hit", key_hit,   32'd0);
        chk("unk_tgt", target_id, 32'd4);
        step();
        chk("unk_req", load_req,  32'd0);
        chk("unk_auto", auto_mode, 32'd0);

        // Auto slideshow from image 1
        pulse(1);
        serve("pre_auto", 3'd1, 5);
        pulse(14);
        chk("auto_on",  auto_mode, 32'd1);
        chk("auto_hit", key_hit,   32'd1);
        for (int i = 0; i < 99; i++) step();
        chk("auto_pre_tick", target_id, 32'd1);
        step();
        chk("auto_tick", target_id, 32'd2);
        step();
        chk("auto_req", load_req, 32'd1);
        serve("auto2", 3'd2, 2);
        exp_id = 3'd3;
        for (int j = 0; j < 6; j++) begin
            serve("auto_seq", exp_id, 200);
            exp_id = exp_id + 3'd1;
        end
        chk("auto_wrap_cur", cur_id, 32'd0);
        pulse(14);
        chk("auto_off", auto_mode, 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 250; i++) begin
            step();
            saw = saw | load_req;
        end
        chk("auto_off_noreq", saw, 32'd0);

        // Ack timeout and retry
        pulse(6);
        step();
        chk("to_req", load_req, 32'd1);
        n = 0;
        while (load_req === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk("to_len",  n,       32'd50);
        chk("to_err",  ack_err, 32'd1);
        chk("to_cur",  cur_id,  32'd0);
        step();
        chk("to_retry",    load_req, 32'd1);
        chk("to_retry_id", load_id,  32'd6);
        chk("to_err_hold", ack_err,  32'd1);
        serve("to_ack", 3'd6, 2);
        chk("to_err_clr", ack_err, 32'd0);

        // Async reset mid-request
        pulse(3);
        step();
        chk("ar_req", load_req, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("ar");
        step();
        rst_n = 1'b1;
        step();
        chk("ar_boot_req", load_req, 32'd1);
        chk("ar_boot_id",  load_id,  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
